// File: rtl/cla_bist.sv
// cla_bist: built-in self-test initiator for a carry-lookahead adder.
// It drives pseudo-random operands from a 16-bit Galois LFSR and samples
// {cout,sum} LAT edges after each operand load. Each sample is compared with
// an internal golden sum, counted on mismatch (saturating), and folded into a
// 16-bit MISR signature.
// Optional build macro CLA_BIST_CORNER_EN: four fixed corner vectors run
// before the LFSR vectors. These corner vectors do not advance the LFSR.
module cla_bist #(
    parameter int WIDTH = 4,
    parameter int N_VEC = 64,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [15:0]      signature
);

`ifdef CLA_BIST_CORNER_EN
    localparam int N_CORNER = 4;
`else
    localparam int N_CORNER = 0;
`endif
    localparam int TOTAL  = N_VEC + N_CORNER;
    localparam int VEC_W  = $clog2(TOTAL + 1);
    localparam int WAIT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // One right-shift step of the Galois register (taps 0xB400); shared by LFSR and MISR.
    function automatic logic [15:0] galois_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

`ifdef CLA_BIST_CORNER_EN
    // Alternating pattern 1010... read from the MSB downwards.
    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < WIDTH; k++) p[WIDTH-1-k] = (k % 2 == 0);
        return p;
    endfunction
    localparam logic [WIDTH-1:0] ALT_A = alt_pattern();
    logic [VEC_W-1:0] load_idx;
`endif

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0]       err_q, err_d;
    logic [15:0]      sig_q, sig_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [WIDTH-1:0] ld_a, ld_b;
    logic             ld_cin, ld_step, load_now;
    logic [WIDTH:0]   golden, resp;

    // Golden sum from the registered operands, and the response as sampled.
    assign golden = {1'b0, op_a_q} + {1'b0, op_b_q} + {{WIDTH{1'b0}}, op_cin_q};
    assign resp   = {dut_cout, dut_sum};

    // Operands for the next load: a corner vector or a slice of the current LFSR.
    always_comb begin
        ld_a    = lfsr_q[WIDTH-1:0];
        ld_b    = lfsr_q[2*WIDTH-1:WIDTH];
        ld_cin  = lfsr_q[15];
        ld_step = 1'b1;
`ifdef CLA_BIST_CORNER_EN
        load_idx = (state_q == S_RUN) ? vec_q + 1'b1 : '0;
        if (load_idx < VEC_W'(4)) begin
            ld_step = 1'b0;
            ld_cin  = 1'b1;
            case (load_idx[1:0])
                2'd0:    begin ld_a = '0;    ld_b = '0;     ld_cin = 1'b0; end
                2'd1:    begin ld_a = '1;    ld_b = '1;     end
                2'd2:    begin ld_a = '1;    ld_b = '0;     end
                default: begin ld_a = ALT_A; ld_b = ~ALT_A; end
            endcase
        end
`endif
    end

    // Next-state logic: start handling, LAT-edge wait, sample/check/sign, next load.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        sig_d    = sig_q;
        wait_d   = wait_q;
        vec_d    = vec_q;
        load_now = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    sig_d    = '0;
                    vec_d    = '0;
                    wait_d   = '0;
                    load_now = 1'b1;
                end
            end
            S_RUN: begin
                if (wait_q == WAIT_W'(LAT - 1)) begin
                    if (resp != golden && err_q != 8'hFF) err_d = err_q + 8'd1;
                    sig_d = galois_step(sig_q) ^ {{(15 - WIDTH){1'b0}}, resp};
                    if (vec_q == VEC_W'(TOTAL - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 8'd0);
                    end else begin
                        vec_d    = vec_q + 1'b1;
                        wait_d   = '0;
                        load_now = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load_now) begin
            op_a_d   = ld_a;
            op_b_d   = ld_b;
            op_cin_d = ld_cin;
            if (ld_step) lfsr_d = galois_step(lfsr_q);
        end
    end

    // State register; reset restores the seed and clears all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 16'hACE1;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            sig_q    <= '0;
            wait_q   <= '0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            sig_q    <= sig_d;
            wait_q   <= wait_d;
            vec_q    <= vec_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_cin    = op_cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: instance 0 (N_VEC=64, LAT=1, combinational adder) and
// instance 1 (N_VEC=300, LAT=3, registered adder), exercised one at a time.
// A run prediction pushes expected operand vectors and the expected final
// result into queues; a monitor pops and compares them against the selected instance.
module tb_cla_bist;
    localparam int W = 4;
    localparam int NV0 = 64, LAT0 = 1, NV1 = 300, LAT1 = 3;
`ifdef CLA_BIST_CORNER_EN
    localparam int NC = 4;
`else
    localparam int NC = 0;
`endif

    typedef struct {
        int          start_cyc;
        int          exp_cycles;
        logic [7:0]  err;
        logic [15:0] sig;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    int   mode0 = 0, mode1 = 0;
    logic sel = 1'b0;

    logic [W-1:0] op_a0, op_b0, sum0, op_a1, op_b1, sum1;
    logic         op_cin0, cout0, busy0, done0, pass0;
    logic         op_cin1, cout1, busy1, done1, pass1;
    logic [7:0]   err0, err1;
    logic [15:0]  sig0, sig1;
    logic [W:0]   reg_resp1 = '0;

    int n_checks = 0, n_err = 0, cyc = 0, runs_seen = 0, win = 0;
    logic [15:0] m_lfsr [2];
    logic [8:0]  vq [$];
    res_t        rq [$];
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test: mode 0 correct, 1 sum bit0 stuck at 0, 2 carry-out inverted.
    function automatic logic [4:0] adder_f(input int mode, input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] g;
        g = {1'b0, a} + {1'b0, b} + {4'b0, c};
        case (mode)
            1:       return g & 5'b11110;
            2:       return g ^ 5'b10000;
            default: return g;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign {cout0, sum0} = adder_f(mode0, op_a0, op_b0, op_cin0);
    always @(posedge clk) reg_resp1 <= adder_f(mode1, op_a1, op_b1, op_cin1);
    assign {cout1, sum1} = reg_resp1;

    cla_bist #(.WIDTH(W), .N_VEC(NV0), .LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .op_a(op_a0), .op_b(op_b0), .op_cin(op_cin0),
        .dut_sum(sum0), .dut_cout(cout0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .signature(sig0)
    );

    cla_bist #(.WIDTH(W), .N_VEC(NV1), .LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
        .dut_sum(sum1), .dut_cout(cout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .signature(sig1)
    );

    logic [8:0]  m_ops;
    logic        m_busy, m_done, m_pass;
    logic [7:0]  m_err;
    logic [15:0] m_sig;
    assign m_ops  = sel ? {op_cin1, op_b1, op_a1} : {op_cin0, op_b0, op_a0};
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_err  = sel ? err1 : err0;
    assign m_sig  = sel ? sig1 : sig0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected vectors and final result of one run from the bench's own model.
    task automatic predict(input int inst, input int mode, input int nvec, input int lat);
        res_t        r;
        logic [15:0] l, sig;
        logic [3:0]  a, b;
        logic        c;
        logic [4:0]  g, rsp;
        int          err;
        l = m_lfsr[inst];
        sig = '0;
        err = 0;
        for (int k = 0; k < nvec + NC; k++) begin
            if (k < NC) begin
                case (k)
                    0:       begin a = 4'h0; b = 4'h0; c = 1'b0; end
                    1:       begin a = 4'hF; b = 4'hF; c = 1'b1; end
                    2:       begin a = 4'hF; b = 4'h0; c = 1'b1; end
                    default: begin a = 4'hA; b = 4'h5; c = 1'b1; end
                endcase
            end else begin
                a = l[3:0];
                b = l[7:4];
                c = l[15];
                l = lfsr_next(l);
            end
            vq.push_back({c, b, a});
            g = {1'b0, a} + {1'b0, b} + {4'b0, c};
            rsp = adder_f(mode, a, b, c);
            if (rsp != g && err < 255) err++;
            sig = lfsr_next(sig) ^ {11'b0, rsp};
        end
        m_lfsr[inst] = l;
        r.start_cyc  = cyc + 1;
        r.exp_cycles = (nvec + NC) * lat;
        r.err        = 8'(err);
        r.sig        = sig;
        r.pass       = (err == 0);
        rq.push_back(r);
    endtask

    // Monitor: operand vectors while busy, final result when done rises.
    always @(negedge clk) begin
        res_t r;
        if (m_busy) begin
            if (vq.size() == 0) begin
                check("vec_queue_underrun", 32'(vq.size()), 32'd1);
            end else begin
                check("operands", 32'(m_ops), 32'(vq[0]));
                win++;
                if (win == (sel ? LAT1 : LAT0)) begin
                    void'(vq.pop_front());
                    win = 0;
                end
            end
        end
        if (m_done && !done_prev) begin
            if (rq.size() == 0) begin
                check("unexpected_done", 32'(rq.size()), 32'd1);
            end else begin
                r = rq.pop_front();
                check("done_latency", 32'(cyc - r.start_cyc), 32'(r.exp_cycles));
                check("err_count", 32'(m_err), 32'(r.err));
                check("signature", 32'(m_sig), 32'(r.sig));
                check("pass", 32'(m_pass), 32'(r.pass));
                check("busy_at_done", 32'(m_busy), 32'd0);
                check("vectors_left", 32'(vq.size()), 32'd0);
            end
            runs_seen++;
        end
        done_prev = m_done;
    end

    task automatic check_reset0(input string tag);
        check({tag, "_op_a"}, 32'(op_a0), 32'd0);
        check({tag, "_op_b"}, 32'(op_b0), 32'd0);
        check({tag, "_op_cin"}, 32'(op_cin0), 32'd0);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_pass"}, 32'(pass0), 32'd0);
        check({tag, "_err"}, 32'(err0), 32'd0);
        check({tag, "_sig"}, 32'(sig0), 32'd0);
    endtask

    // One complete run on the chosen instance; optional stray start while busy.
    task automatic do_run(input int inst, input int mode, input int glitch);
        int target, nv, lat;
        nv = inst ? NV1 : NV0;
        lat = inst ? LAT1 : LAT0;
        sel = inst[0];
        win = 0;
        if (inst == 0) mode0 = mode; else mode1 = mode;
        target = runs_seen + 1;
        predict(inst, mode, nv, lat);
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (glitch > 0) begin
            repeat (glitch) @(posedge clk);
            #1;
            if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
            @(posedge clk); #1;
            start0 = 1'b0;
            start1 = 1'b0;
        end
        for (int i = 0; i < (nv + NC) * lat + 20 && runs_seen < target; i++) @(posedge clk);
        #1;
        if (runs_seen < target) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: inst %0d no done, required within %0d edges", inst, (nv + NC) * lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no end, required end");
        $fatal(1, "watchdog");
    end

    initial begin
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'hACE1;
        repeat (2) @(posedge clk);
        #1;
        check_reset0("reset");
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_done1", 32'(done1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_run(0, 0, 0);
        do_run(0, 1, 0);
        check("sum0_err_nonzero", 32'(err0 != 8'd0), 32'd1);
        do_run(0, 0, 10);

        // Reset in the middle of a run, then replay from the seed.
        sel = 1'b0;
        mode0 = 0;
        win = 0;
        predict(0, 0, NV0, LAT0);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vq.delete();
        rq.delete();
        win = 0;
        check_reset0("midrst");
        m_lfsr[0] = 16'hACE1;
        do_run(0, 0, 0);

        do_run(1, 0, 0);
        do_run(1, 2, 0);
        check("sat_err_count", 32'(err1), 32'hFF);
        check("sat_pass", 32'(pass1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cla_bist.md
Name: cla_bist

Overview:
- Built-in self-test initiator for the carry-lookahead adder datapath.
- Drives pseudo-random operands into the adder's inputs and reads back its sum and carry-out.
- Compares every result against an internal golden sum, counts mismatches and compresses all responses into a signature.
- Sits beside the adder in the user project; the host starts a run and reads pass/fail.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..7.
- N_VEC, 64, vectors per run (after corner vectors, if enabled); ≥1.
- LAT, 1, clock edges from operand update to result sample; ≥1 (1 = combinational adder).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- op_a  output  WIDTH  operand A to adder.
- op_b  output  WIDTH  operand B to adder.
- op_cin  output  1  carry-in to adder.
- dut_sum  input  WIDTH  adder sum.
- dut_cout  input  1  adder carry-out.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or rst.
- pass  output  1  valid with done; 1 when err_count==0.
- err_count  output  8  mismatching vectors, saturating at 255.
- signature  output  16  MISR over all sampled {dut_cout,dut_sum}.

Behaviour:
- Reset (rst high at an edge):
  - op_a=0, op_b=0, op_cin=0; busy=0, done=0, pass=0, err_count=0, signature=0x0000.
  - LFSR=0xACE1, state=IDLE, wait counter=0, vector counter=0.
  - Reset wins over all other events, including mid-run.
- LFSR: 16-bit Galois, right shift. Step: lsb=l[0]; l=l>>1; if lsb, l^=0xB400.
- Operand load from the current LFSR value: op_a=l[WIDTH-1:0], op_b=l[2*WIDTH-1:WIDTH], op_cin=l[15]. LFSR steps on the same edge.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at an edge:
  - Go to RUN, busy←1, done←0, pass←0, err_count←0, signature←0, vector counter←0.
  - Load first operands (from the seed 0xACE1 on the first run after reset; from the current LFSR value on a later run — no reseed).
- RUN: wait counter counts LAT edges after each operand load. On the LAT-th edge (sample edge):
  - golden={1'b0,op_a}+{1'b0,op_b}+op_cin, WIDTH+1 bits, computed from the registered operands.
  - If {dut_cout,dut_sum}≠golden: err_count+1, saturating at 255.
  - signature←galois_step(signature) XOR zero-extended {dut_cout,dut_sum}.
  - If this was the last vector: state←DONE, busy←0, done←1, pass←(final err_count==0). Operands hold their last values.
  - Otherwise: load the next operands on the same edge.
- Timing: done rises exactly N_VEC*LAT edges after the start edge (plus corner vectors, if enabled).
- start while busy is ignored.
- start held high in DONE immediately restarts a run.
- Operands are stable for the full LAT window; they never change between load and sample.

Optional Feature:
- Macro: CLA_BIST_CORNER_EN.
- Defined: four fixed corner vectors precede the LFSR vectors, in this order:
  1. a=0, b=0, cin=0.
  2. a=all-ones, b=all-ones, cin=1.
  3. a=all-ones, b=0, cin=1.
  4. a=alternating 1010…, b=alternating 0101…, cin=1.
  - Corner vectors do not step the LFSR. They are checked and signed like LFSR vectors.
  - done rises (N_VEC+4)*LAT edges after start.
- Undefined: LFSR vectors only; no corner logic present.

Test Plan:
- Correct combinational adder model, WIDTH=4, LAT=1, N_VEC=64, pulse start → busy=1 for 64 cycles; done=1, pass=1, err_count=0; signature equals the bench MISR model.
- dut_sum[0] forced to 0 → done after 64 cycles, pass=0, err_count equals the bench count of vectors with golden bit0=1 (>0).
- dut_cout inverted, N_VEC=300 → err_count=255 (saturated), pass=0.
- LAT=3, registered adder model → done exactly 192 edges after start; operands unchanged within each 3-cycle window; pass=1.
- rst high for 1 cycle at vector 20 → next edge: all outputs at reset values; a new start replays from seed 0xACE1 and gives an identical signature.
- start pulsed during RUN → ignored, done timing unchanged.
- With CLA_BIST_CORNER_EN, N_VEC=1, LAT=1 → op_a=0xF, op_b=0xF, op_cin=1 on the 2nd vector; done at edge 5.
